// File: rtl/mxu_pkg.sv
// Shared definitions for the matrix unit's AXI4-Lite host interface.
// The address decode lives here so the write path can reuse it.
package mxu_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   localparam logic [15:0] STATUS_ADDR = 16'h8000;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WAIT,
      RESP
   } rd_state_t;

   typedef enum logic [1:0] {
      CLS_BUF,
      CLS_STAT,
      CLS_SLVERR,
      CLS_DECERR
   } addr_cls_t;

   // Misalignment is reported before any region match is attempted.
   function automatic addr_cls_t decode_addr(input logic [31:0] addr,
                                             input int unsigned buf_words);
      if (addr[1:0] != 2'b00)
         return CLS_SLVERR;
      if (addr < (buf_words << 2))
         return CLS_BUF;
      if (addr == 32'(STATUS_ADDR))
         return CLS_STAT;
      return CLS_DECERR;
   endfunction

   function automatic logic [31:0] status_word(input logic done,
                                               input logic busy,
                                               input int unsigned size);
      return {16'h0000, 8'(size), 6'b000000, busy, done};
   endfunction

endpackage

// File: rtl/mxu_axil_read.sv
// AXI4-Lite read responder: serves the result buffer and the status register
// with a fixed three-cycle address-to-data latency and one read outstanding.
module mxu_axil_read
   import mxu_pkg::*;
#(
   parameter int SIZE   = 16,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [ADDR_W-1:0]             araddr,
   input  logic                          arvalid,
   output logic                          arready,
   output logic [DATA_W-1:0]             rdata,
   output logic [1:0]                    rresp,
   output logic                          rvalid,
   input  logic                          rready,
   output logic                          mem_en,
   output logic [$clog2(SIZE*SIZE)-1:0]  mem_addr,
   input  logic [31:0]                   mem_rdata,
   input  logic                          mxu_done,
   input  logic                          mxu_busy,
   output logic                          done_clr
);

   localparam int          MEM_AW    = $clog2(SIZE*SIZE);
   localparam int unsigned BUF_WORDS = SIZE * SIZE;

   rd_state_t state;
   addr_cls_t cls_q;
   addr_cls_t ar_cls;

   assign ar_cls = decode_addr(32'(araddr), BUF_WORDS);

   // The buffer read is issued at the handshake edge so that mem_en is high
   // exactly during FETCH and the data lands while the FSM sits in WAIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cls_q    <= CLS_DECERR;
         arready  <= 1'b0;
         rvalid   <= 1'b0;
         rdata    <= '0;
         rresp    <= RESP_OKAY;
         mem_en   <= 1'b0;
         mem_addr <= '0;
         done_clr <= 1'b0;
      end else begin
         mem_en   <= 1'b0;
         done_clr <= 1'b0;
         case (state)
            IDLE: begin
               arready <= 1'b1;
               if (arvalid && arready) begin
                  arready  <= 1'b0;
                  cls_q    <= ar_cls;
                  mem_en   <= (ar_cls == CLS_BUF);
                  mem_addr <= MEM_AW'(araddr >> 2);
                  state    <= FETCH;
               end
            end
            FETCH: begin
               state <= WAIT;
            end
            WAIT: begin
               case (cls_q)
                  CLS_BUF: begin
                     rdata <= mem_rdata;
                     rresp <= RESP_OKAY;
                  end
                  CLS_STAT: begin
                     rdata    <= status_word(mxu_done, mxu_busy, SIZE);
                     rresp    <= RESP_OKAY;
                     done_clr <= 1'b1;
                  end
                  CLS_SLVERR: begin
                     rdata <= '0;
                     rresp <= RESP_SLVERR;
                  end
                  default: begin
                     rdata <= '0;
                     rresp <= RESP_DECERR;
                  end
               endcase
               rvalid <= 1'b1;
               state  <= RESP;
            end
            RESP: begin
               if (rready) begin
                  rvalid  <= 1'b0;
                  arready <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
